dma_row_writer: RTL and testbench

DMA_ROW_WRITER -- requirements
Module: dma_row_writer

---
 rtl/dma_row_writer_if.sv | 29 ++
 rtl/dma_row_writer.sv | 111 +++++++++++
 tb/tb_dma_row_writer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_row_writer_if.sv
// dma_row_writer_if: control, row-stream and RAM-port signals of the DMA row writer.
interface dma_row_writer_if #(
    parameter int ROW_SIZE   = 16,
    parameter int BLOCK_SIZE = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]  row_count;
    logic                  abort;
    logic [ROW_SIZE-1:0]   row_in;
    logic                  row_valid;
    logic                  row_ready;
    logic                  ram_enable;
    logic                  ram_write;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [BLOCK_SIZE-1:0] output_to_ram;
    logic                  busy;
    logic                  done;
    modport master (
        output start, base_addr, row_count, abort, row_in, row_valid,
        input  row_ready, ram_enable, ram_write, ram_address, output_to_ram, busy, done
    );
    modport slave (
        input  start, base_addr, row_count, abort, row_in, row_valid,
        output row_ready, ram_enable, ram_write, ram_address, output_to_ram, busy, done
    );
endinterface

// File: rtl/dma_row_writer.sv
// dma_row_writer: writes row_count decompressed rows to RAM, one BLOCK_SIZE slice per cycle,
// LSB slice first, at consecutive addresses starting at base_addr.
module dma_row_writer #(
    parameter int ROW_SIZE   = 16,
    parameter int BLOCK_SIZE = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input logic              clk,
    input logic              rst_n,
    dma_row_writer_if.slave  bus
);
    localparam int BPR = ROW_SIZE / BLOCK_SIZE;
    localparam int BW  = BPR > 1 ? $clog2(BPR) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ROW, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, ram_address_q, ram_address_d;
    logic [CNT_WIDTH-1:0]  rows_q, rows_d;
    logic [ROW_SIZE-1:0]   row_q, row_d;
    logic [BW-1:0]         blk_q, blk_d;
    logic [BLOCK_SIZE-1:0] output_to_ram_q, output_to_ram_d;
    logic                  row_ready_q, row_ready_d, ram_en_q, ram_en_d;
    logic                  busy_q, busy_d, done_q, done_d, beat;

    // blk_q indexes the beat currently on the RAM port; row_q holds the slices still to go
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rows_d          = rows_q;
        row_d           = row_q;
        blk_d           = blk_q;
        ram_address_d   = ram_address_q;
        output_to_ram_d = output_to_ram_q;
        done_d          = 1'b0;
        beat            = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                addr_d  = bus.base_addr;
                rows_d  = bus.row_count;
                state_d = bus.row_count != '0 ? WAIT_ROW : DONE;
            end
            WAIT_ROW: if (bus.abort) state_d = IDLE;
            else if (bus.row_valid && row_ready_q) begin
                blk_d           = '0;
                beat            = 1'b1;
                output_to_ram_d = bus.row_in[BLOCK_SIZE-1:0];
                row_d           = bus.row_in >> BLOCK_SIZE;
                state_d         = WRITE;
            end
            WRITE: if (bus.abort) state_d = IDLE;
            else if (blk_q == BW'(BPR - 1)) begin
                rows_d  = rows_q - 1'b1;
                state_d = rows_d != '0 ? WAIT_ROW : DONE;
            end else begin
                blk_d           = blk_q + 1'b1;
                beat            = 1'b1;
                output_to_ram_d = row_q[BLOCK_SIZE-1:0];
                row_d           = row_q >> BLOCK_SIZE;
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ram_en_d      = beat;
        ram_address_d = beat ? addr_q : ram_address_d;
        addr_d        = beat ? addr_q + 1'b1 : addr_d;
        row_ready_d   = state_d == WAIT_ROW;
        // busy stays up through the registered done pulse that follows the DONE state
        busy_d        = state_d != IDLE || done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rows_q          <= '0;
            row_q           <= '0;
            blk_q           <= '0;
            ram_address_q   <= '0;
            output_to_ram_q <= '0;
            row_ready_q     <= 1'b0;
            ram_en_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rows_q          <= rows_d;
            row_q           <= row_d;
            blk_q           <= blk_d;
            ram_address_q   <= ram_address_d;
            output_to_ram_q <= output_to_ram_d;
            row_ready_q     <= row_ready_d;
            ram_en_q        <= ram_en_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign bus.row_ready     = row_ready_q;
    assign bus.ram_enable    = ram_en_q;
    assign bus.ram_write     = ram_en_q;
    assign bus.ram_address   = ram_address_q;
    assign bus.output_to_ram = output_to_ram_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_dma_row_writer.sv
// tb_dma_row_writer: scenario tasks with a write scoreboard checked on every falling edge.
module tb_dma_row_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dma_row_writer_if bus ();
    dma_row_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;
    logic [15:0] exp_addr;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic start_xfer(input logic [15:0] base, input logic [7:0] cnt);
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.row_count = cnt;
        exp_addr = base;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic push_beats(input logic [15:0] data, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({exp_addr, data[k*4 +: 4]});
            exp_addr = exp_addr + 16'd1;
        end
    endtask

    task automatic send_row(input logic [15:0] data);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) if (bus.row_ready === 1'b1) ok = 1'b1; else tick();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL row_ready_timeout: row_ready=%b required 1", bus.row_ready);
        end
        bus.row_valid = 1'b1;
        bus.row_in = data;
        push_beats(data, 4);
        tick();
        bus.row_valid = 1'b0;
        bus.row_in = ~data;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.ram_enable !== 1'b1) begin
                errors++;
                $display("FAIL beat_gap: beat %0d ram_enable=%b required 1", k, bus.ram_enable);
            end
            tick();
        end
    endtask

    task automatic wait_done;
        bit seen = 1'b0;
        int d0 = done_cnt;
        for (int i = 0; i < 20 && !seen; i++) if (bus.done === 1'b1) seen = 1'b1; else tick();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: done=%b required 1", bus.done);
        end
        tick();
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL after_done: done,busy=%b required 00", {bus.done, bus.busy});
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d required 1", done_cnt - d0);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL missing_writes: %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.row_ready, bus.ram_enable, bus.ram_write, bus.busy, bus.done, bus.ram_address, bus.output_to_ram} !== 25'd0) begin
            errors++;
            $display("FAIL reset_state: rdy,en,wr,busy,done=%b addr=%h data=%h required all 0",
                     {bus.row_ready, bus.ram_enable, bus.ram_write, bus.busy, bus.done}, bus.ram_address, bus.output_to_ram);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        start_xfer(16'h0010, 8'd2);
        checks++;
        if ({bus.busy, bus.row_ready, bus.done} !== 3'b110) begin
            errors++;
            $display("FAIL start_accept: busy,rdy,done=%b required 110", {bus.busy, bus.row_ready, bus.done});
        end
        send_row(16'hABCD);
        send_row(16'h1234);
        wait_done();
    endtask

    task automatic test_zero_rows;
        int n = 0;
        int d0 = done_cnt;
        start_xfer(16'h0050, 8'd0);
        while (bus.busy === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL zero_rows_busy: busy cycles %0d required 2", n);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL zero_rows_done: pulses %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_wrap;
        start_xfer(16'hFFFE, 8'd1);
        send_row(16'h5678);
        wait_done();
    endtask

    task automatic test_stall;
        start_xfer(16'h0100, 8'd1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.row_ready, bus.ram_enable} !== 2'b10) begin
                errors++;
                $display("FAIL stall: cycle %0d rdy,en=%b required 10", i, {bus.row_ready, bus.ram_enable});
            end
            if (i == 2) begin
                bus.start = 1'b1;
                bus.base_addr = 16'h0200;
                bus.row_count = 8'd3;
            end
            tick();
            bus.start = 1'b0;
        end
        send_row(16'h9ABC);
        wait_done();
    endtask

    task automatic test_abort;
        int d0;
        start_xfer(16'h0040, 8'd2);
        bus.row_valid = 1'b1;
        bus.row_in = 16'hC3A5;
        push_beats(16'hC3A5, 2);
        tick();
        bus.row_valid = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.ram_enable, bus.ram_write, bus.busy, bus.row_ready, bus.done} !== 5'b0) begin
            errors++;
            $display("FAIL abort: en,wr,busy,rdy,done=%b required 00000",
                     {bus.ram_enable, bus.ram_write, bus.busy, bus.row_ready, bus.done});
        end
        d0 = done_cnt;
        repeat (5) tick();
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL abort_done: pulses %0d required 0", done_cnt - d0);
        end
        start_xfer(16'h0080, 8'd1);
        send_row(16'h0F1E);
        wait_done();
    endtask

    task automatic test_reset_mid;
        start_xfer(16'h0300, 8'd1);
        bus.row_valid = 1'b1;
        bus.row_in = 16'hBEEF;
        push_beats(16'hBEEF, 2);
        tick();
        bus.row_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.row_ready, bus.ram_enable, bus.ram_write, bus.busy, bus.done, bus.ram_address, bus.output_to_ram} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid: rdy,en,wr,busy,done=%b addr=%h data=%h required all 0",
                     {bus.row_ready, bus.ram_enable, bus.ram_write, bus.busy, bus.done}, bus.ram_address, bus.output_to_ram);
        end
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.busy, bus.row_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy,rdy=%b required 00", {bus.busy, bus.row_ready});
        end
        start_xfer(16'h0400, 8'd1);
        send_row(16'h1357);
        wait_done();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.row_count = '0;
        bus.abort = 1'b0;
        bus.row_in = '0;
        bus.row_valid = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (bus.done === 1'b1) done_cnt++;
                checks++;
                if (bus.ram_enable !== bus.ram_write) begin
                    errors++;
                    $display("FAIL strobe_pair: en=%b wr=%b required equal", bus.ram_enable, bus.ram_write);
                end
                if (bus.ram_enable === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr=%h data=%h required no write", bus.ram_address, bus.output_to_ram);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if ({bus.ram_address, bus.output_to_ram} !== mon_e) begin
                            errors++;
                            $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                                     bus.ram_address, bus.output_to_ram, mon_e[19:4], mon_e[3:0]);
                        end
                    end
                end
            end
        join_none
        tick();
        test_reset();
        test_basic();
        test_zero_rows();
        test_wrap();
        test_stall();
        test_abort();
        test_reset_mid();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
